multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control
Interface
REQ-001 SHALL have parameter OPW, default 6, opcode and funct field width.
REQ-002 SHALL have ports: clk input 1 clock; rst_n input 1 asynchronous active-low reset; op input OPW instr[31:26]; funct input OPW instr[5:0]; zero input 1 ALU zero flag; mem_ready input 1 memory access complete.
REQ-003 SHALL have outputs: iord 1; mem_write 1; ir_write 1; reg_dst 1; mem_to_reg 1; reg_write 1; alu_src_a 1; alu_src_b 2 (00 B, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2); alu_control 3; pc_src 2 (00 ALU, 01 ALUOut, 10 jump target); pc_en 1; state 4 (debug).
Function
REQ-004 SHALL be a Moore FSM, one transition per clk rising edge, encoding FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7 BRANCH=8 ADDIEX=9 ADDIWB=10 JUMP=11; state output equals current encoding.
REQ-005 Unlisted outputs SHALL be 0 in each state; alu_control SHALL be add (010) unless stated.
REQ-006 FETCH: alu_src_b=01, pc_src=00; ir_write=1 and pc_en=1 only while mem_ready=1; stays in FETCH while mem_ready=0, else DECODE.
REQ-007 DECODE: alu_src_b=11 (branch target into ALUOut); next by op: 100011/101011 MEMADR, 000000 EXEC, 000100 BRANCH, 001000 ADDIEX, 000010 JUMP, any other FETCH.
REQ-008 MEMADR: alu_src_a=1, alu_src_b=10; next MEMRD if op=100011, else MEMWR.
REQ-009 MEMRD: iord=1; holds until mem_ready=1, then MEMWB.
REQ-010 MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; next FETCH.
REQ-011 MEMWR: iord=1, mem_write=1 held every cycle until mem_ready=1; next FETCH on that cycle.
REQ-012 EXEC: alu_src_a=1, alu_src_b=00; alu_control from funct: 100000 010, 100010 110, 100100 000, 100101 001, 101010 111, other 010; next ALUWB.
REQ-013 ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1; next FETCH.
REQ-014 BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01; pc_en=zero (combinational, same cycle); next FETCH.
REQ-015 ADDIEX: alu_src_a=1, alu_src_b=10; next ADDIWB. ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1; next FETCH.
REQ-016 JUMP: pc_src=10, pc_en=1; next FETCH.
REQ-017 pc_en SHALL be 0 in all states not named in REQ-006, REQ-014, REQ-016.
REQ-018 op/funct SHALL be sampled only in DECODE/MEMADR/EXEC respectively; changes elsewhere SHALL have no effect.
REQ-019 Unused encodings 12-15 SHALL transition to FETCH with all write enables 0.
Reset
REQ-020 rst_n=0 SHALL force state FETCH immediately, independent of clk.
REQ-021 During reset all write enables (ir_write, pc_en, mem_write, reg_write) SHALL be 0 regardless of mem_ready; remaining outputs SHALL take FETCH values.
REQ-022 Reset asserted mid-instruction (any state, incl. a stalled MEMWR) SHALL abort it; first cycle after release SHALL be FETCH.
Configuration
REQ-023 Macro MULTICYCLE_BNE_EN SHALL, when defined, decode op=000101 in DECODE to BRANCH_NE (encoding 12): outputs as BRANCH, pc_en=~zero, next FETCH.
REQ-024 Without MULTICYCLE_BNE_EN, op=000101 SHALL go DECODE->FETCH and encoding 12 SHALL follow REQ-019.
Verification
REQ-025 Reset then op=100011, mem_ready=1 always -> state 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in MEMWB.
REQ-026 op=101011, mem_ready low 3 cycles in MEMWR -> mem_write=1 for 4 consecutive cycles, then FETCH.
REQ-027 op=000000 funct=101010 -> EXEC alu_control=111, ALUWB reg_dst=1 reg_write=1; funct=111111 -> 010.
REQ-028 op=000100 with zero=1 -> pc_en=1 in BRANCH, pc_src=01; with zero=0 -> pc_en=0.
REQ-029 rst_n pulsed low in MEMRD while mem_ready=0 -> state 0 asynchronously, no write enables during reset, FETCH after release.
REQ-030 op=000101 zero=0 -> with MULTICYCLE_BNE_EN state 12 pc_en=1; without it DECODE->FETCH, pc_en=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM with registered state-decoded outputs.
// Define MULTICYCLE_BNE_EN to add the BRANCH_NE state (op 000101).
module multicycle_control #(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] op,
    input  logic [OPW-1:0] funct,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           iord,
    output logic           mem_write,
    output logic           ir_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [2:0]     alu_control,
    output logic [1:0]     pc_src,
    output logic           pc_en,
    output logic [3:0]     state
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEMADR    = 4'd2,
        MEMRD     = 4'd3,
        MEMWB     = 4'd4,
        MEMWR     = 4'd5,
        EXEC      = 4'd6,
        ALUWB     = 4'd7,
        BRANCH    = 4'd8,
        ADDIEX    = 4'd9,
        ADDIWB    = 4'd10,
        JUMP      = 4'd11,
        BRANCH_NE = 4'd12
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] pc_src;
    } ctrl_t;

    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_RTYP = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);
`ifdef MULTICYCLE_BNE_EN
    localparam logic [OPW-1:0] OP_BNE  = OPW'(6'b000101);
`endif

    state_t cur_state;
    state_t nxt_state;
    ctrl_t  ctrl;

    // Outputs that depend on state alone; everything not set stays 0 with an add ALU op.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        c.alu_control = 3'b010;
        case (s)
            FETCH:  c.alu_src_b = 2'b01;
            DECODE: c.alu_src_b = 2'b11;
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD:  c.iord = 1'b1;
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            EXEC:   c.alu_src_a = 1'b1;
            ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = 3'b110;
                c.pc_src      = 2'b01;
            end
`ifdef MULTICYCLE_BNE_EN
            BRANCH_NE: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = 3'b110;
                c.pc_src      = 2'b01;
            end
`endif
            ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ADDIWB: c.reg_write = 1'b1;
            JUMP:   c.pc_src = 2'b10;
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] alu_of_funct(input logic [OPW-1:0] f);
        logic [2:0] a;
        case (f)
            OPW'(6'b100000): a = 3'b010;
            OPW'(6'b100010): a = 3'b110;
            OPW'(6'b100100): a = 3'b000;
            OPW'(6'b100101): a = 3'b001;
            OPW'(6'b101010): a = 3'b111;
            default:         a = 3'b010;
        endcase
        return a;
    endfunction

    always_comb begin
        nxt_state = FETCH;
        case (cur_state)
            FETCH:  nxt_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (op == OP_LW || op == OP_SW) nxt_state = MEMADR;
                else if (op == OP_RTYP)         nxt_state = EXEC;
                else if (op == OP_BEQ)          nxt_state = BRANCH;
                else if (op == OP_ADDI)         nxt_state = ADDIEX;
                else if (op == OP_J)            nxt_state = JUMP;
`ifdef MULTICYCLE_BNE_EN
                else if (op == OP_BNE)          nxt_state = BRANCH_NE;
`endif
                else                            nxt_state = FETCH;
            end
            MEMADR: nxt_state = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  nxt_state = mem_ready ? MEMWB : MEMRD;
            MEMWR:  nxt_state = mem_ready ? FETCH : MEMWR;
            EXEC:   nxt_state = ALUWB;
            ADDIEX: nxt_state = ADDIWB;
            default: nxt_state = FETCH;
        endcase
    end

    // The control word is registered together with the state so it tracks the new state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= FETCH;
            ctrl      <= ctrl_of(FETCH);
        end else begin
            cur_state <= nxt_state;
            ctrl      <= ctrl_of(nxt_state);
        end
    end

    // Enables that follow mem_ready/zero within the cycle; rst_n gates them while reset is held.
    always_comb begin
        pc_en = 1'b0;
        case (cur_state)
            FETCH:     pc_en = mem_ready;
            BRANCH:    pc_en = zero;
            JUMP:      pc_en = 1'b1;
`ifdef MULTICYCLE_BNE_EN
            BRANCH_NE: pc_en = ~zero;
`endif
            default:   pc_en = 1'b0;
        endcase
        pc_en = pc_en & rst_n;
    end

    assign ir_write    = rst_n & mem_ready & (cur_state == FETCH);
    assign iord        = ctrl.iord;
    assign mem_write   = ctrl.mem_write;
    assign reg_dst     = ctrl.reg_dst;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign reg_write   = ctrl.reg_write;
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign alu_control = (cur_state == EXEC) ? alu_of_funct(funct) : ctrl.alu_control;
    assign pc_src      = ctrl.pc_src;
    assign state       = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: vector table, directed corner sequences, randomized run vs. phase-queue model.
module tb_multicycle_control;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BNE = 6'b000101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = '0, funct = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    multicycle_control #(.OPW(6)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en),
        .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control, pc_src, pc_en}
    function automatic logic [14:0] outs_now();
        return {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                alu_src_b, alu_control, pc_src, pc_en};
    endfunction

    function automatic logic [14:0] mk(input logic io, mw, ir, rd, mtr, rw, a,
                                       input logic [1:0] b, input logic [2:0] alu,
                                       input logic [1:0] pcs, input logic pe);
        return {io, mw, ir, rd, mtr, rw, a, b, alu, pcs, pe};
    endfunction

    logic [14:0] tab [16];

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        logic [5:0] fs [5];
        logic [2:0] as [5];
        logic [2:0] r;
        fs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        as = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        r = 3'b010;
        for (int i = 0; i < 5; i++) if (fs[i] == f) r = as[i];
        return r;
    endfunction

    function automatic logic [14:0] model_out(input int s, input logic mr, input logic z,
                                              input logic [5:0] f);
        logic [14:0] o;
        o = tab[s];
        if (s == 0) begin
            o[12] = mr;
            o[0]  = mr;
        end
        if (s == 8) o[0] = z;
`ifdef MULTICYCLE_BNE_EN
        if (s == 12) o[0] = ~z;
`endif
        if (s == 6) o[5:3] = funct_alu(f);
        return o;
    endfunction

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       mr;
        logic [3:0] st;
        logic       ir, pcen, rw, mw, mtr;
        logic [2:0] alu;
        logic [1:0] pcs;
    } vec_t;

    vec_t vt[$];

    task automatic addv(input logic [5:0] o, f, input logic z, mr, input logic [3:0] st,
                        input logic ir, pe, rw, mw, mtr, input logic [2:0] alu,
                        input logic [1:0] pcs);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.mr = mr; v.st = st;
        v.ir = ir; v.pcen = pe; v.rw = rw; v.mw = mw; v.mtr = mtr; v.alu = alu; v.pcs = pcs;
        vt.push_back(v);
    endtask

    task automatic step(input logic [5:0] o, f, input logic z, mr);
        @(negedge clk);
        op = o; funct = f; zero = z; mem_ready = mr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("reset_state", state, 0);
        check("reset_outs", outs_now(), mk(0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0));
        rst_n = 1'b1;
    endtask

    logic [5:0] op_pool [8];
    logic [5:0] fn_pool [6];
    int         exp_st;
    int         nxt;
    int         q[$];
    int         mw_run;

    initial begin
        for (int s = 0; s < 16; s++) tab[s] = mk(0,0,0,0,0,0,0,2'b00,3'b010,2'b00,0);
        tab[0]  = mk(0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0);
        tab[1]  = mk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0);
        tab[2]  = mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0);
        tab[3]  = mk(1,0,0,0,0,0,0,2'b00,3'b010,2'b00,0);
        tab[4]  = mk(0,0,0,0,1,1,0,2'b00,3'b010,2'b00,0);
        tab[5]  = mk(1,1,0,0,0,0,0,2'b00,3'b010,2'b00,0);
        tab[6]  = mk(0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0);
        tab[7]  = mk(0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0);
        tab[8]  = mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0);
        tab[9]  = mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0);
        tab[10] = mk(0,0,0,0,0,1,0,2'b00,3'b010,2'b00,0);
        tab[11] = mk(0,0,0,0,0,0,0,2'b00,3'b010,2'b10,1);
`ifdef MULTICYCLE_BNE_EN
        tab[12] = mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0);
`endif

        // op, funct, zero, mr, state, ir, pc_en, reg_write, mem_write, mem_to_reg, alu, pc_src
        addv(LW,  6'h00, 0, 1, 0, 1, 1, 0, 0, 0, 3'b010, 2'b00);
        addv(LW,  6'h00, 0, 1, 1, 0, 0, 0, 0, 0, 3'b010, 2'b00);
        addv(LW,  6'h00, 0, 1, 2, 0, 0, 0, 0, 0, 3'b010, 2'b00);
        addv(LW,  6'h00, 0, 1, 3, 0, 0, 0, 0, 0, 3'b010, 2'b00);
        addv(LW,  6'h00, 0, 1, 4, 0, 0, 1, 0, 1, 3'b010, 2'b00);
        addv(RT,  6'b101010, 0, 1, 0, 1, 1, 0, 0, 0, 3'b010, 2'b00);
        addv(RT,  6'b101010, 0, 1, 1, 0, 0, 0, 0, 0, 3'b010, 2'b00);
        addv(RT,  6'b101010, 0, 1, 6, 0, 0, 0, 0, 0, 3'b111, 2'b00);
        addv(RT,  6'b101010, 0, 1, 7, 0, 0, 1, 0, 0, 3'b010, 2'b00);
        addv(RT,  6'b111111, 0, 1, 0, 1, 1, 0, 0, 0, 3'b010, 2'b00);
        addv(RT,  6'b111111, 0, 1, 1, 0, 0, 0, 0, 0, 3'b010, 2'b00);
        addv(RT,  6'b111111, 0, 1, 6, 0, 0, 0, 0, 0, 3'b010, 2'b00);
        addv(RT,  6'b111111, 0, 1, 7, 0, 0, 1, 0, 0, 3'b010, 2'b00);
        addv(BEQ, 6'h00, 1, 1, 0, 1, 1, 0, 0, 0, 3'b010, 2'b00);
        addv(BEQ, 6'h00, 1, 1, 1, 0, 0, 0, 0, 0, 3'b010, 2'b00);
        addv(BEQ, 6'h00, 1, 1, 8, 0, 1, 0, 0, 0, 3'b110, 2'b01);
        addv(BEQ, 6'h00, 0, 1, 0, 1, 1, 0, 0, 0, 3'b010, 2'b00);
        addv(BEQ, 6'h00, 0, 1, 1, 0, 0, 0, 0, 0, 3'b010, 2'b00);
        addv(BEQ, 6'h00, 0, 1, 8, 0, 0, 0, 0, 0, 3'b110, 2'b01);
        addv(ADDI,6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00);
        addv(ADDI,6'h00, 0, 1, 0, 1, 1, 0, 0, 0, 3'b010, 2'b00);
        addv(ADDI,6'h00, 0, 1, 1, 0, 0, 0, 0, 0, 3'b010, 2'b00);
        addv(ADDI,6'h00, 0, 1, 9, 0, 0, 0, 0, 0, 3'b010, 2'b00);
        addv(ADDI,6'h00, 0, 1, 10,0, 0, 1, 0, 0, 3'b010, 2'b00);
        addv(JMP, 6'h00, 0, 1, 0, 1, 1, 0, 0, 0, 3'b010, 2'b00);
        addv(JMP, 6'h00, 0, 1, 1, 0, 0, 0, 0, 0, 3'b010, 2'b00);
        addv(JMP, 6'h00, 0, 1, 11,0, 1, 0, 0, 0, 3'b010, 2'b10);
        addv(LW,  6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00);

        do_reset();
        foreach (vt[i]) begin
            step(vt[i].op, vt[i].funct, vt[i].zero, vt[i].mr);
            check($sformatf("vec%0d_state", i), state, vt[i].st);
            check($sformatf("vec%0d_outs", i),
                  {ir_write, pc_en, reg_write, mem_write, mem_to_reg, alu_control, pc_src},
                  {vt[i].ir, vt[i].pcen, vt[i].rw, vt[i].mw, vt[i].mtr, vt[i].alu, vt[i].pcs});
        end

        // Store stalled three cycles in MEMWR.
        do_reset();
        step(SW, 0, 0, 1);
        step(SW, 0, 0, 1);
        step(SW, 0, 0, 1);
        check("sw_memadr", state, 2);
        mw_run = 0;
        for (int i = 0; i < 4; i++) begin
            step(SW, 0, 0, i == 3);
            check($sformatf("sw_stall%0d_state", i), state, 5);
            if (mem_write) mw_run++;
        end
        check("sw_mem_write_cycles", mw_run, 4);
        step(SW, 0, 0, 0);
        check("sw_back_to_fetch", {state, mem_write}, {4'd0, 1'b0});

        // Reset pulse in a stalled MEMRD.
        do_reset();
        step(LW, 0, 0, 1);
        step(LW, 0, 0, 1);
        step(LW, 0, 0, 1);
        step(LW, 0, 0, 0);
        check("lw_memrd_stall", state, 3);
        #2;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("async_reset_state", state, 0);
        check("async_reset_enables", {ir_write, pc_en, mem_write, reg_write}, 4'b0000);
        check("async_reset_alu_src_b", alu_src_b, 2'b01);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("after_release_state", state, 0);
        step(LW, 0, 0, 1);
        check("after_release_fetch", {state, ir_write}, {4'd0, 1'b1});

        // bne with zero=0.
        do_reset();
        step(BNE, 0, 0, 1);
        step(BNE, 0, 0, 1);
        check("bne_decode", state, 1);
        step(BNE, 0, 0, 0);
`ifdef MULTICYCLE_BNE_EN
        check("bne_state", {state, pc_en}, {4'd12, 1'b1});
`else
        check("bne_state", {state, pc_en}, {4'd0, 1'b0});
`endif

        // Randomized run against the instruction-phase model.
        op_pool = '{LW, SW, RT, BEQ, ADDI, JMP, BNE, 6'h3f};
        fn_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'h00};
        do_reset();
        exp_st = 0;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 59) != 0);
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 7)];
            funct = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 5)];
            zero = 1'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (!rst_n) begin
                exp_st = 0;
                q.delete();
                check("rand_reset_state", state, 0);
                check("rand_reset_outs", outs_now(), model_out(0, 1'b0, zero, funct));
            end else begin
                check($sformatf("rand%0d_state", c), state, exp_st);
                check($sformatf("rand%0d_outs", c), outs_now(),
                      model_out(exp_st, mem_ready, zero, funct));
                if ((exp_st == 0 || exp_st == 3 || exp_st == 5) && !mem_ready) begin
                    nxt = exp_st;
                end else if (exp_st == 0) begin
                    nxt = 1;
                end else if (exp_st == 1) begin
                    q.delete();
                    if (op == LW || op == SW) q.push_back(2);
                    else if (op == RT) begin q.push_back(6); q.push_back(7); end
                    else if (op == BEQ) q.push_back(8);
                    else if (op == ADDI) begin q.push_back(9); q.push_back(10); end
                    else if (op == JMP) q.push_back(11);
`ifdef MULTICYCLE_BNE_EN
                    else if (op == BNE) q.push_back(12);
`endif
                    nxt = (q.size() != 0) ? q.pop_front() : 0;
                end else if (exp_st == 2) begin
                    if (op == LW) begin q.push_back(3); q.push_back(4); end
                    else q.push_back(5);
                    nxt = q.pop_front();
                end else begin
                    nxt = (q.size() != 0) ? q.pop_front() : 0;
                end
                exp_st = nxt;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
